ps2_mouse_tracker: RTL and testbench

- Produces the absolute 10-bit pointer coordinates that drive the rope simulation's mouse inputs.
- Receives the PS/2 mouse device-to-host serial stream and decodes standard 3-byte movement packets.
- Accumulates signed deltas into a screen-clamped position and presents it with a one-cycle update strobe.

---
 rtl/ps2_mouse_tracker.sv | 182 ++++++++++++++++++
 tb/tb_ps2_mouse_tracker.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse receiver: decodes 3-byte movement packets and tracks a
// screen-clamped absolute pointer position with a one-cycle update strobe.
module ps2_mouse_tracker #(
    parameter int unsigned SCREEN_W       = 640,
    parameter int unsigned SCREEN_H       = 480,
    parameter int unsigned INIT_X         = 320,
    parameter int unsigned INIT_Y         = 240,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] mouse_x,
    output logic [9:0] mouse_y,
    output logic [2:0] buttons,
    output logic       pos_valid,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PW = 12;
    localparam logic signed [PW-1:0] X_MAX = PW'(SCREEN_W - 1);
    localparam logic signed [PW-1:0] Y_MAX = PW'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      pclk_sync;
    logic [1:0]      pdat_sync;
    logic            fall_c, bit_c;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic            shift_en_c, byte_done_c, byte_good_c;
    logic [1:0]      idx_q;
    logic [6:0]      hdr_q;      // {ovf_y, ovf_x, sign_y, sign_x, btn[2:0]}
    logic [7:0]      dx_lo_q;
    logic [TW-1:0]   tmo_q;
    logic            active_c, timeout_c;
    logic signed [PW-1:0] dx_c, dy_c, nx_c, ny_c;

    // Two-flop synchronisers plus one extra clock stage for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pclk_sync <= '0;
            pdat_sync <= '0;
        end else begin
            pclk_sync <= {pclk_sync[1:0], ps2_clk};
            pdat_sync <= {pdat_sync[0], ps2_data};
        end
    end

    assign fall_c = pclk_sync[2] & ~pclk_sync[1];
    assign bit_c  = pdat_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = ST_IDLE;
        end else if (fall_c) begin
            case (state_q)
                ST_IDLE:   if (!bit_c) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        shift_en_c  = 1'b0;
        byte_done_c = 1'b0;
        byte_good_c = 1'b0;
        if (fall_c) begin
            case (state_q)
                ST_DATA: shift_en_c = 1'b1;
                ST_STOP: begin
                    byte_done_c = 1'b1;
                    byte_good_c = (^{shift_q, par_q}) & bit_c;
                end
                default: ;
            endcase
        end
    end

    // Bit shifter: LSB arrives first, so shift in from the top
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
        end else begin
            if (fall_c && state_q == ST_IDLE) bit_cnt_q <= '0;
            if (shift_en_c) begin
                shift_q   <= {bit_c, shift_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (fall_c && state_q == ST_PARITY) par_q <= bit_c;
        end
    end

    assign active_c  = (state_q != ST_IDLE) || (idx_q != 2'd0);
    assign timeout_c = active_c && !fall_c && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             tmo_q <= '0;
        else if (fall_c || !active_c || timeout_c) tmo_q <= '0;
        else                                    tmo_q <= tmo_q + TW'(1);
    end

    // Overflowed axes contribute no motion; y is inverted because PS/2 +y is up
    always_comb begin
        dx_c = hdr_q[5] ? '0 : {{(PW-8){hdr_q[3]}}, dx_lo_q};
        dy_c = hdr_q[6] ? '0 : {{(PW-8){hdr_q[4]}}, shift_q};
        nx_c = $signed({2'b00, mouse_x}) + dx_c;
        ny_c = $signed({2'b00, mouse_y}) - dy_c;
    end

    function automatic logic [9:0] clamp(input logic signed [PW-1:0] v,
                                         input logic signed [PW-1:0] vmax);
        if (v[PW-1])      return 10'd0;
        else if (v > vmax) return vmax[9:0];
        else              return v[9:0];
    endfunction

    // Packet assembly and position update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q     <= 2'd0;
            hdr_q     <= '0;
            dx_lo_q   <= '0;
            mouse_x   <= 10'(INIT_X);
            mouse_y   <= 10'(INIT_Y);
            buttons   <= '0;
            pos_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            pos_valid <= 1'b0;
            frame_err <= 1'b0;
            if (timeout_c) begin
                idx_q <= 2'd0;
            end else if (byte_done_c) begin
                if (!byte_good_c) begin
                    frame_err <= 1'b1;
                    idx_q     <= 2'd0;
                end else begin
                    case (idx_q)
                        2'd0: if (shift_q[3]) begin
                            hdr_q <= {shift_q[7:4], shift_q[2:0]};
                            idx_q <= 2'd1;
                        end
                        2'd1: begin
                            dx_lo_q <= shift_q;
                            idx_q   <= 2'd2;
                        end
                        2'd2: begin
                            mouse_x   <= clamp(nx_c, X_MAX);
                            mouse_y   <= clamp(ny_c, Y_MAX);
                            buttons   <= hdr_q[2:0];
                            pos_valid <= 1'b1;
                            idx_q     <= 2'd0;
                        end
                        default: idx_q <= 2'd0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Bench for ps2_mouse_tracker: drives PS/2 frames and compares against a
// packet-level reference model of the pointer position.
module tb_ps2_mouse_tracker;

    localparam int SW = 640;
    localparam int SH = 480;
    localparam int IX = 320;
    localparam int IY = 240;
    localparam int TO = 2000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] mouse_x, mouse_y;
    logic [2:0] buttons;
    logic       pos_valid, frame_err;

    ps2_mouse_tracker #(
        .SCREEN_W(SW), .SCREEN_H(SH), .INIT_X(IX), .INIT_Y(IY), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .buttons(buttons),
        .pos_valid(pos_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Strobe monitor: counts high cycles of each strobe and any overlap
    int pv_cnt = 0, fe_cnt = 0, both_cnt = 0;
    always @(negedge clk) begin
        if (pos_valid === 1'b1) pv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (pos_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    // Reference model (packet level)
    int m_x, m_y, m_idx, exp_pv = 0, exp_fe = 0;
    logic [2:0] m_btn;
    logic [7:0] m_hdr, m_b1;

    function automatic int clampi(input int v, input int vmax);
        if (v < 0) return 0;
        if (v > vmax) return vmax;
        return v;
    endfunction

    task automatic model_reset();
        m_x = IX; m_y = IY; m_btn = 3'b000; m_idx = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        int dx, dy;
        if (!ok) begin
            exp_fe++;
            m_idx = 0;
        end else if (m_idx == 0) begin
            if (b[3]) begin m_hdr = b; m_idx = 1; end
        end else if (m_idx == 1) begin
            m_b1 = b; m_idx = 2;
        end else begin
            dx = m_hdr[6] ? 0 : (m_hdr[4] ? int'(m_b1) - 256 : int'(m_b1));
            dy = m_hdr[7] ? 0 : (m_hdr[5] ? int'(b) - 256 : int'(b));
            m_x = clampi(m_x + dx, SW - 1);
            m_y = clampi(m_y - dy, SH - 1);
            m_btn = m_hdr[2:0];
            exp_pv++;
            m_idx = 0;
        end
    endtask

    // Drive one 11-bit frame; hit returns the negedges (1..8) after the
    // stop-bit falling edge at which pos_valid was seen high
    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit bad_stop, output logic [8:0] hit);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        hit = '0;
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                if (i == 10 && pos_valid === 1'b1) hit[k] = 1'b1;
            end
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        ps2_data = 1'b1;
        model_byte(b, !bad_par && !bad_stop);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, output logic [8:0] hit);
        logic [8:0] h;
        send_frame(b0, 0, 0, h);
        send_frame(b1, 0, 0, h);
        send_frame(b2, 0, 0, hit);
    endtask

    // Start bit plus nbits data bits, then the clock stops
    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [8:0] f;
        f = {b, 1'b0};
        for (int i = 0; i <= nbits; i++) begin
            ps2_data = f[i];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (8) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (mouse_x !== 10'(IX) || mouse_y !== 10'(IY) || buttons !== 3'b000 ||
            pos_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: x=%0d y=%0d btn=%b pv=%b fe=%b, required x=%0d y=%0d btn=000 pv=0 fe=0",
                     mouse_x, mouse_y, buttons, pos_valid, frame_err, IX, IY);
        end
        reset = 1'b1;
        repeat (2 * TO) @(negedge clk);
        checks++;
        if (pv_cnt != 0 || fe_cnt != 0 || mouse_x !== 10'(IX) || mouse_y !== 10'(IY)) begin
            errors++;
            $display("FAIL idle_quiet: pv=%0d fe=%0d x=%0d y=%0d, required 0 0 %0d %0d",
                     pv_cnt, fe_cnt, mouse_x, mouse_y, IX, IY);
        end
    endtask

    task automatic test_basic();
        logic [8:0] hit;
        send_packet(8'h08, 8'h0A, 8'h05, hit);
        checks++;
        if (mouse_x !== 10'd330 || mouse_y !== 10'd235 || buttons !== 3'b000) begin
            errors++;
            $display("FAIL basic_move: x=%0d y=%0d btn=%b, required 330 235 000", mouse_x, mouse_y, buttons);
        end
        checks++;
        if (hit !== 9'b000001000) begin
            errors++;
            $display("FAIL pos_valid_timing: seen at %b, required 000001000", hit);
        end
        send_packet(8'h19, 8'hF6, 8'h00, hit);
        checks++;
        if (mouse_x !== 10'(m_x) || mouse_y !== 10'(m_y) || buttons !== m_btn ||
            mouse_x !== 10'd320 || buttons !== 3'b001) begin
            errors++;
            $display("FAIL basic_neg: x=%0d y=%0d btn=%b, required %0d %0d %b",
                     mouse_x, mouse_y, buttons, m_x, m_y, m_btn);
        end
        checks++;
        if (pv_cnt != exp_pv || fe_cnt != exp_fe) begin
            errors++;
            $display("FAIL basic_strobes: pv=%0d fe=%0d, required %0d %0d", pv_cnt, fe_cnt, exp_pv, exp_fe);
        end
    endtask

    task automatic test_clamp();
        logic [8:0] hit;
        logic [7:0] pk [4][3];
        pk[0] = '{8'h08, 8'hFF, 8'h00};
        pk[1] = '{8'h08, 8'hFF, 8'h00};
        pk[2] = '{8'h28, 8'h00, 8'h01};
        pk[3] = '{8'h28, 8'h00, 8'h01};
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        for (int p = 0; p < 4; p++) begin
            send_packet(pk[p][0], pk[p][1], pk[p][2], hit);
            checks++;
            if (mouse_x !== 10'(m_x) || mouse_y !== 10'(m_y) || buttons !== m_btn) begin
                errors++;
                $display("FAIL clamp_%0d: x=%0d y=%0d btn=%b, required %0d %0d %b",
                         p, mouse_x, mouse_y, buttons, m_x, m_y, m_btn);
            end
        end
        checks++;
        if (mouse_x !== 10'd639 || mouse_y !== 10'd479) begin
            errors++;
            $display("FAIL clamp_limits: x=%0d y=%0d, required 639 479", mouse_x, mouse_y);
        end
    endtask

    task automatic test_frame_errors();
        logic [8:0] hit;
        int x0, y0, pv0, fe0;
        x0 = m_x; y0 = m_y; pv0 = pv_cnt; fe0 = fe_cnt;
        send_frame(8'h08, 0, 0, hit);
        send_frame(8'h05, 1, 0, hit);
        send_frame(8'h03, 0, 0, hit);
        checks++;
        if (fe_cnt - fe0 != 1 || pv_cnt != pv0 || mouse_x !== 10'(x0) || mouse_y !== 10'(y0)) begin
            errors++;
            $display("FAIL parity_err: fe_pulses=%0d pv_pulses=%0d x=%0d y=%0d, required 1 0 %0d %0d",
                     fe_cnt - fe0, pv_cnt - pv0, mouse_x, mouse_y, x0, y0);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        send_packet(8'h08, 8'h01, 8'h00, hit);
        checks++;
        if (mouse_x !== 10'd321 || mouse_y !== 10'(m_y)) begin
            errors++;
            $display("FAIL after_parity: x=%0d y=%0d, required 321 %0d", mouse_x, mouse_y, m_y);
        end
        fe0 = fe_cnt;
        send_frame(8'h08, 0, 1, hit);
        send_packet(8'h08, 8'h04, 8'hFE, hit);
        checks++;
        if (fe_cnt - fe0 != 1 || mouse_x !== 10'(m_x) || mouse_y !== 10'(m_y)) begin
            errors++;
            $display("FAIL stop_err: fe_pulses=%0d x=%0d y=%0d, required 1 %0d %0d",
                     fe_cnt - fe0, mouse_x, mouse_y, m_x, m_y);
        end
    endtask

    task automatic test_resync();
        logic [8:0] hit;
        int pv0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        pv0 = pv_cnt;
        send_frame(8'h00, 0, 0, hit);
        send_packet(8'h08, 8'h02, 8'h00, hit);
        checks++;
        if (pv_cnt - pv0 != 1 || mouse_x !== 10'd322 || mouse_x !== 10'(m_x)) begin
            errors++;
            $display("FAIL resync: pv_pulses=%0d x=%0d, required 1 322", pv_cnt - pv0, mouse_x);
        end
    endtask

    task automatic test_timeout();
        logic [8:0] hit;
        int pv0, fe0, x0, y0;
        pv0 = pv_cnt; fe0 = fe_cnt; x0 = m_x; y0 = m_y;
        send_partial(8'h5A, 4);
        repeat (TO + 20) @(negedge clk);
        checks++;
        if (pv_cnt != pv0 || fe_cnt != fe0 || mouse_x !== 10'(x0) || mouse_y !== 10'(y0)) begin
            errors++;
            $display("FAIL timeout_bits: pv=%0d fe=%0d x=%0d y=%0d, required %0d %0d %0d %0d",
                     pv_cnt, fe_cnt, mouse_x, mouse_y, pv0, fe0, x0, y0);
        end
        send_packet(8'h08, 8'h07, 8'h02, hit);
        checks++;
        if (mouse_x !== 10'(m_x) || mouse_y !== 10'(m_y)) begin
            errors++;
            $display("FAIL timeout_recover: x=%0d y=%0d, required %0d %0d", mouse_x, mouse_y, m_x, m_y);
        end
        // Abandon a packet between bytes
        send_frame(8'h09, 0, 0, hit);
        repeat (TO + 20) @(negedge clk);
        m_idx = 0;
        send_packet(8'h0A, 8'h10, 8'h10, hit);
        checks++;
        if (mouse_x !== 10'(m_x) || mouse_y !== 10'(m_y) || buttons !== m_btn || fe_cnt != exp_fe) begin
            errors++;
            $display("FAIL timeout_packet: x=%0d y=%0d btn=%b fe=%0d, required %0d %0d %b %0d",
                     mouse_x, mouse_y, buttons, fe_cnt, m_x, m_y, m_btn, exp_fe);
        end
    endtask

    task automatic test_overflow();
        logic [8:0] hit;
        int x0, y0;
        x0 = m_x; y0 = m_y;
        send_packet(8'h48, 8'h7F, 8'h03, hit);
        checks++;
        if (mouse_x !== 10'(x0) || mouse_y !== 10'(y0 - 3) || mouse_y !== 10'(m_y)) begin
            errors++;
            $display("FAIL x_overflow: x=%0d y=%0d, required %0d %0d", mouse_x, mouse_y, x0, y0 - 3);
        end
    endtask

    task automatic test_random();
        logic [8:0] hit;
        logic [7:0] b0, b1, b2;
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 4) == 0) send_frame(8'($urandom) & 8'hF7, 0, 0, hit);
            b0 = 8'($urandom) | 8'h08;
            if ($urandom_range(0, 7) != 0) b0 = b0 & 8'h3F;
            b1 = 8'($urandom);
            b2 = 8'($urandom);
            send_packet(b0, b1, b2, hit);
            checks++;
            if (mouse_x !== 10'(m_x) || mouse_y !== 10'(m_y) || buttons !== m_btn || hit !== 9'b000001000) begin
                errors++;
                $display("FAIL random_%0d (%h %h %h): x=%0d y=%0d btn=%b pv_at=%b, required %0d %0d %b 000001000",
                         n, b0, b1, b2, mouse_x, mouse_y, buttons, hit, m_x, m_y, m_btn);
            end
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        checks++;
        if (pv_cnt != exp_pv || fe_cnt != exp_fe || both_cnt != 0) begin
            errors++;
            $display("FAIL strobe_totals: pv=%0d fe=%0d both=%0d, required %0d %0d 0",
                     pv_cnt, fe_cnt, both_cnt, exp_pv, exp_fe);
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] hit;
        send_frame(8'h0B, 0, 0, hit);
        send_partial(8'h33, 3);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (mouse_x !== 10'(IX) || mouse_y !== 10'(IY) || buttons !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid: x=%0d y=%0d btn=%b, required %0d %0d 000", mouse_x, mouse_y, buttons, IX, IY);
        end
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send_packet(8'h3E, 8'hE0, 8'hC0, hit);
        checks++;
        if (mouse_x !== 10'(m_x) || mouse_y !== 10'(m_y) || buttons !== m_btn) begin
            errors++;
            $display("FAIL after_reset_mid: x=%0d y=%0d btn=%b, required %0d %0d %b",
                     mouse_x, mouse_y, buttons, m_x, m_y, m_btn);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_frame_errors();
        test_resync();
        test_timeout();
        test_overflow();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
